// File: rtl/aclk_fsm.sv
// aclk_fsm -- alarm-clock keypad/display control FSM.
//
// Sequences keypad digit entry into a shift register, then commits the keyed
// digits to either the alarm register or the clock counter, and selects what
// the display shows. Key entry is abandoned after TIMEOUT_SEC one_second
// pulses without a new digit.
//
// Ports:
//   clk            system clock, all state changes on rising edge
//   reset          asynchronous active-high reset
//   one_second     one-clk-wide pulse once per second
//   alarm_button   level, high while alarm button held
//   time_button    level, high while time button held
//   key[3:0]       keypad code: 0-9 digit, NOKEY (and 11-15) idle
//   load_new_a     strobe: alarm register captures keyed digits
//   load_new_c     strobe: clock counter loads keyed time
//   show_a         display selects stored alarm time
//   show_new_time  display selects keyed digits
//   shift          strobe: key shift register shifts in key
module aclk_fsm #(
  parameter int unsigned TIMEOUT_SEC = 10,
  parameter logic [3:0]  NOKEY       = 4'd10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_second,
  input  logic       alarm_button,
  input  logic       time_button,
  input  logic [3:0] key,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       show_a,
  output logic       show_new_time,
  output logic       shift
);

  localparam int unsigned CW = (TIMEOUT_SEC > 1) ? $clog2(TIMEOUT_SEC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_SEC - 1);

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    KEY_STORED       = 3'd1,
    KEY_WAITED       = 3'd2,
    KEY_ENTRY        = 3'd3,
    SHOW_ALARM       = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          key_digit;
  logic          timeout;
  logic          cur_timed;
  logic          nxt_timed;

  assign key_digit = (key != NOKEY) && (key <= 4'd9);
  assign timeout   = one_second && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SHOW_TIME: begin
        if (alarm_button)   state_d = SHOW_ALARM;
        else if (key_digit) state_d = KEY_STORED;
      end
      KEY_STORED: state_d = KEY_WAITED;
      KEY_WAITED: begin
        if (!key_digit)     state_d = KEY_ENTRY;
        else if (timeout)   state_d = SHOW_TIME;
      end
      KEY_ENTRY: begin
        if (alarm_button)      state_d = SET_ALARM_TIME;
        else if (time_button)  state_d = SET_CURRENT_TIME;
        else if (key_digit)    state_d = KEY_STORED;
        else if (timeout)      state_d = SHOW_TIME;
      end
      SHOW_ALARM: begin
        if (!alarm_button)  state_d = SHOW_TIME;
      end
      SET_ALARM_TIME:   state_d = SHOW_TIME;
      SET_CURRENT_TIME: state_d = SHOW_TIME;
      default:          state_d = SHOW_TIME;
    endcase
  end

  // The count survives only while staying inside the waited/entry pair, so
  // entry to KEY_STORED (or any other state) clears it. It saturates at
  // CNT_LAST: a key release coincident with the final pulse must not wrap.
  assign cur_timed = (state_q == KEY_WAITED) || (state_q == KEY_ENTRY);
  assign nxt_timed = (state_d == KEY_WAITED) || (state_d == KEY_ENTRY);

  always_comb begin
    cnt_d = '0;
    if (cur_timed && nxt_timed) begin
      if (one_second && (cnt_q != CNT_LAST)) cnt_d = cnt_q + 1'b1;
      else                                   cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SHOW_TIME;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    load_new_a    = 1'b0;
    load_new_c    = 1'b0;
    show_a        = 1'b0;
    show_new_time = 1'b0;
    shift         = 1'b0;
    unique case (state_q)
      KEY_STORED: begin
        shift         = 1'b1;
        show_new_time = 1'b1;
      end
      KEY_WAITED:       show_new_time = 1'b1;
      KEY_ENTRY:        show_new_time = 1'b1;
      SHOW_ALARM:       show_a        = 1'b1;
      SET_ALARM_TIME:   load_new_a    = 1'b1;
      SET_CURRENT_TIME: load_new_c    = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/aclk_fsm.md
ACLK_FSM -- requirements
Module: aclk_fsm

Interface
REQ-001 Parameter TIMEOUT_SEC, default 10: one_second pulses of key inactivity before key-entry mode is abandoned.
REQ-002 Parameter NOKEY, default 4'd10: key code meaning no key pressed.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 one_second  input  1  one-clk-wide pulse, once per second.
REQ-006 alarm_button  input  1  level, high while alarm button held.
REQ-007 time_button  input  1  level, high while time button held.
REQ-008 key  input  4  keypad code: 0-9 digit, NOKEY idle; 11-15 treated as NOKEY.
REQ-009 load_new_a  output  1  one-cycle strobe to the alarm register to capture the keyed digits.
REQ-010 load_new_c  output  1  one-cycle strobe to the clock counter to load the keyed time.
REQ-011 show_a  output  1  display selects stored alarm time.
REQ-012 show_new_time  output  1  display selects keyed digits.
REQ-013 shift  output  1  one-cycle strobe to the key shift register to shift in key.

Function
REQ-014 Moore FSM, states: SHOW_TIME, KEY_STORED, KEY_WAITED, KEY_ENTRY, SHOW_ALARM, SET_ALARM_TIME, SET_CURRENT_TIME; outputs decoded from registered state only.
REQ-015 SHOW_TIME: alarm_button=1 -> SHOW_ALARM; else valid digit (0-9) -> KEY_STORED; else stay.
REQ-016 KEY_STORED: unconditionally -> KEY_WAITED after exactly one cycle; shift=1 only here.
REQ-017 KEY_WAITED: key released (NOKEY or 11-15) -> KEY_ENTRY; else timeout -> SHOW_TIME; else stay (held key shifts once only).
REQ-018 KEY_ENTRY priority: alarm_button -> SET_ALARM_TIME; else time_button -> SET_CURRENT_TIME; else valid digit -> KEY_STORED; else timeout -> SHOW_TIME; else stay.
REQ-019 SHOW_ALARM: alarm_button=0 -> SHOW_TIME; else stay; time_button and key ignored.
REQ-020 SET_ALARM_TIME: -> SHOW_TIME after one cycle; load_new_a=1 only here.
REQ-021 SET_CURRENT_TIME: -> SHOW_TIME after one cycle; load_new_c=1 only here.
REQ-022 show_new_time=1 in KEY_STORED, KEY_WAITED, KEY_ENTRY; show_a=1 in SHOW_ALARM only; all other outputs 0 in all other states.
REQ-023 Timeout counter: width ceil(log2(TIMEOUT_SEC)) bits; cleared in every state except KEY_WAITED and KEY_ENTRY, and cleared on entry to KEY_STORED.
REQ-024 Counter increments on one_second=1 while in KEY_WAITED or KEY_ENTRY; count persists across KEY_WAITED->KEY_ENTRY.
REQ-025 Timeout condition: count==TIMEOUT_SEC-1 and one_second=1 in the same cycle; i.e. the TIMEOUT_SEC-th pulse since the last digit; counter never wraps.
REQ-026 Timeout coincident with a valid digit in KEY_ENTRY: digit wins (REQ-018 priority), counter cleared.
REQ-027 At most one of load_new_a, load_new_c, shift high in any cycle.

Reset
REQ-028 reset=1 forces state SHOW_TIME and timeout count 0 immediately, independent of clk.
REQ-029 During and after reset until first transition: all five outputs 0.
REQ-030 Reset asserted mid-entry (any state) discards the entry; no load strobe issued; FSM resumes from SHOW_TIME on first clk edge after deassertion.

Verification
REQ-031 Digit entry: key=3 for 3 cycles then NOKEY, then 4,5,6 likewise, then alarm_button=1 one cycle -> exactly 4 shift pulses, show_new_time=1 throughout, one load_new_a pulse, back to SHOW_TIME, show_new_time=0.
REQ-032 Time set: key=1 then NOKEY, then time_button=1 -> one shift, one load_new_c pulse, load_new_a stays 0.
REQ-033 Timeout: key=7 then NOKEY, 9 one_second pulses -> still KEY_ENTRY; 10th pulse -> SHOW_TIME next cycle, no load strobe.
REQ-034 Show alarm: alarm_button held 5 cycles from SHOW_TIME -> show_a=1 from cycle after press until cycle after release; key=2 during hold -> no shift.
REQ-035 Simultaneous: in KEY_ENTRY, alarm_button=1, time_button=1 same cycle -> load_new_a only; key=5 with 10th one_second pulse -> KEY_STORED, shift=1.
REQ-036 Async reset: assert reset mid-cycle while in KEY_WAITED -> outputs 0 before next clk edge; after release, key=NOKEY holds SHOW_TIME.
